// File: rtl/trap_sequencer_if.sv
// Signal bundle between the decode/CSR side of the core and the trap sequencer.
// The master drives the boundary and CSR read values; the slave owns the CSR write port and PC control.
interface trap_sequencer_if;
  logic        irq_timer;
  logic        irq_ext;
  logic        inst_valid;
  logic        is_mret;
  logic [31:0] pc_in;
  logic        inst_csr_wr;
  logic [11:0] inst_csr_addr;
  logic [31:0] inst_csr_wdata;
  logic [31:0] csr_mstatus;
  logic [31:0] csr_mie;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;

  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        kill;
  logic        stall;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        busy;

  modport master (
    output irq_timer, irq_ext, inst_valid, is_mret, pc_in,
           inst_csr_wr, inst_csr_addr, inst_csr_wdata,
           csr_mstatus, csr_mie, csr_mtvec, csr_mepc,
    input  csr_we, csr_waddr, csr_wdata, kill, stall,
           pc_redirect, pc_target, busy
  );

  modport slave (
    input  irq_timer, irq_ext, inst_valid, is_mret, pc_in,
           inst_csr_wr, inst_csr_addr, inst_csr_wdata,
           csr_mstatus, csr_mie, csr_mtvec, csr_mepc,
    output csr_we, csr_waddr, csr_wdata, kill, stall,
           pc_redirect, pc_target, busy
  );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / mret sequencer: takes timer and external interrupts at the
// instruction boundary, sequences mepc/mcause/mstatus writes, and redirects the PC.
module trap_sequencer (
  input logic             clk,
  input logic             rst,
  trap_sequencer_if.slave bus
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    IDLE,
    CAUSE,
    STATUS,
    VECTOR,
    RET
  } state_t;

  state_t     state;
  logic [3:0] cause_code;

  logic        ext_pend;
  logic        tmr_pend;
  logic        pend;
  logic        trap_go;
  logic        mret_go;
  logic [3:0]  next_cause;
  logic [31:0] mcause_val;
  logic [31:0] trap_status;
  logic [31:0] mret_status;
  logic [31:0] vec_base;
  logic [31:0] vec_target;

  logic unused_bits;
  assign unused_bits = ^{bus.csr_mie[31:12], bus.csr_mie[10:8], bus.csr_mie[6:0], bus.pc_in[1:0]};

  assign ext_pend   = bus.irq_ext & bus.csr_mie[11];
  assign tmr_pend   = bus.irq_timer & bus.csr_mie[7];
  assign pend       = bus.csr_mstatus[3] & (ext_pend | tmr_pend);
  assign trap_go    = bus.inst_valid & pend;
  assign mret_go    = bus.inst_valid & bus.is_mret & ~pend;
  assign next_cause = ext_pend ? 4'hB : 4'h7;
  assign mcause_val = {1'b1, 27'd0, cause_code};

  always_comb begin
    trap_status        = bus.csr_mstatus;
    trap_status[7]     = bus.csr_mstatus[3];
    trap_status[3]     = 1'b0;
    trap_status[12:11] = 2'b11;
  end

  always_comb begin
    mret_status        = bus.csr_mstatus;
    mret_status[3]     = bus.csr_mstatus[7];
    mret_status[7]     = 1'b1;
    mret_status[12:11] = 2'b11;
  end

  // Vectored mode offsets by 4*cause; only the low cause nibble matters for interrupts.
  assign vec_base   = {bus.csr_mtvec[31:2], 2'b00};
  assign vec_target = (bus.csr_mtvec[1:0] == 2'b01)
                    ? vec_base + {26'd0, cause_code, 2'b00}
                    : vec_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cause_code <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trap_go) begin
            state      <= CAUSE;
            cause_code <= next_cause;
          end else if (mret_go) begin
            state <= RET;
          end
        end
        CAUSE:   state <= STATUS;
        STATUS:  state <= VECTOR;
        VECTOR:  state <= IDLE;
        RET:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.csr_we      = 1'b0;
    bus.csr_waddr   = '0;
    bus.csr_wdata   = '0;
    bus.kill        = 1'b0;
    bus.stall       = 1'b0;
    bus.pc_redirect = 1'b0;
    bus.pc_target   = '0;
    bus.busy        = 1'b0;
    if (!rst) begin
      bus.busy = (state != IDLE);
      case (state)
        IDLE: begin
          if (trap_go) begin
            bus.kill      = 1'b1;
            bus.csr_we    = 1'b1;
            bus.csr_waddr = ADDR_MEPC;
            bus.csr_wdata = {bus.pc_in[31:2], 2'b00};
          end else if (mret_go) begin
            bus.csr_we    = 1'b1;
            bus.csr_waddr = ADDR_MSTATUS;
            bus.csr_wdata = mret_status;
          end else begin
            bus.csr_we    = bus.inst_csr_wr;
            bus.csr_waddr = bus.inst_csr_addr;
            bus.csr_wdata = bus.inst_csr_wdata;
          end
        end
        CAUSE: begin
          bus.stall     = 1'b1;
          bus.csr_we    = 1'b1;
          bus.csr_waddr = ADDR_MCAUSE;
          bus.csr_wdata = mcause_val;
        end
        STATUS: begin
          bus.stall     = 1'b1;
          bus.csr_we    = 1'b1;
          bus.csr_waddr = ADDR_MSTATUS;
          bus.csr_wdata = trap_status;
        end
        VECTOR: begin
          bus.stall       = 1'b1;
          bus.pc_redirect = 1'b1;
          bus.pc_target   = vec_target;
        end
        RET: begin
          bus.stall       = 1'b1;
          bus.pc_redirect = 1'b1;
          bus.pc_target   = bus.csr_mepc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed scenarios then random traffic, checked against a
// schedule-of-operations model that also plays the role of the core's CSR file.
module tb_trap_sequencer;

  logic clk;
  logic rst;
  trap_sequencer_if bus ();

  trap_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {OP_CAUSE, OP_STATUS, OP_VECTOR, OP_RET} op_t;
  typedef struct {
    op_t         op;
    logic [31:0] cause;
  } item_t;

  item_t q[$];
  logic [31:0] m_status, m_mie, m_mtvec, m_mepc, m_mcause;

  logic        o_we, o_kill, o_stall, o_redir, o_busy;
  logic [11:0] o_addr;
  logic [31:0] o_data, o_target;

  int unsigned ncmp;
  int unsigned nfail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] f_trap_status(input logic [31:0] ms);
    return (ms & ~32'h0000_1888) | ((ms & 32'h8) << 4) | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] f_mret_status(input logic [31:0] ms);
    return (ms & ~32'h0000_1888) | ((ms & 32'h80) >> 4) | 32'h80 | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] f_vector(input logic [31:0] tv, input logic [31:0] cause);
    logic [31:0] base;
    base = tv & ~32'h3;
    if ((tv & 32'h3) == 32'h1) return base + 4 * (cause & 32'hF);
    return base;
  endfunction

  task automatic csr_file_write(input logic [11:0] a, input logic [31:0] d);
    case (a)
      12'h300: m_status = d;
      12'h304: m_mie    = d;
      12'h305: m_mtvec  = d;
      12'h341: m_mepc   = d;
      12'h342: m_mcause = d;
      default: ;
    endcase
  endtask

  task automatic idle_in();
    bus.irq_timer      = 1'b0;
    bus.irq_ext        = 1'b0;
    bus.inst_valid     = 1'b0;
    bus.is_mret        = 1'b0;
    bus.pc_in          = '0;
    bus.inst_csr_wr    = 1'b0;
    bus.inst_csr_addr  = '0;
    bus.inst_csr_wdata = '0;
  endtask

  // One clock cycle: present CSR file, sample DUT mid-cycle, compare, then advance the model.
  task automatic tick();
    logic        e_we, e_kill, e_stall, e_redir, e_busy, pend, ext;
    logic [11:0] e_addr;
    logic [31:0] e_data, e_target, cause;
    item_t       it;
    bus.csr_mstatus = m_status;
    bus.csr_mie     = m_mie;
    bus.csr_mtvec   = m_mtvec;
    bus.csr_mepc    = m_mepc;
    #3;
    o_we = bus.csr_we; o_addr = bus.csr_waddr; o_data = bus.csr_wdata; o_kill = bus.kill;
    o_stall = bus.stall; o_redir = bus.pc_redirect; o_target = bus.pc_target; o_busy = bus.busy;

    e_we = 0; e_addr = '0; e_data = '0; e_kill = 0; e_stall = 0; e_redir = 0; e_target = '0; e_busy = 0;
    if (!rst) begin
      if (q.size() > 0) begin
        it = q[0];
        e_stall = 1; e_busy = 1;
        case (it.op)
          OP_CAUSE:  begin e_we = 1; e_addr = 12'h342; e_data = it.cause; end
          OP_STATUS: begin e_we = 1; e_addr = 12'h300; e_data = f_trap_status(m_status); end
          OP_VECTOR: begin e_redir = 1; e_target = f_vector(m_mtvec, it.cause); end
          OP_RET:    begin e_redir = 1; e_target = m_mepc; end
          default: ;
        endcase
      end else begin
        ext  = bus.irq_ext && m_mie[11];
        pend = m_status[3] && (ext || (bus.irq_timer && m_mie[7]));
        if (bus.inst_valid && pend) begin
          cause  = ext ? 32'h8000_000B : 32'h8000_0007;
          e_kill = 1; e_we = 1; e_addr = 12'h341; e_data = bus.pc_in & ~32'h3;
          q.push_back('{OP_CAUSE, cause});
          q.push_back('{OP_STATUS, cause});
          q.push_back('{OP_VECTOR, cause});
        end else if (bus.inst_valid && bus.is_mret) begin
          e_we = 1; e_addr = 12'h300; e_data = f_mret_status(m_status);
          q.push_back('{OP_RET, 32'h0});
        end else begin
          e_we = bus.inst_csr_wr; e_addr = bus.inst_csr_addr; e_data = bus.inst_csr_wdata;
        end
      end
    end

    chk("csr_we",      {31'd0, o_we},    {31'd0, e_we});
    chk("csr_waddr",   {20'd0, o_addr},  {20'd0, e_addr});
    chk("csr_wdata",   o_data,           e_data);
    chk("kill",        {31'd0, o_kill},  {31'd0, e_kill});
    chk("stall",       {31'd0, o_stall}, {31'd0, e_stall});
    chk("pc_redirect", {31'd0, o_redir}, {31'd0, e_redir});
    chk("pc_target",   o_target,         e_target);
    chk("busy",        {31'd0, o_busy},  {31'd0, e_busy});

    if (rst) q.delete();
    else if (e_busy) void'(q.pop_front());
    if (e_we) csr_file_write(e_addr, e_data);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] addrs [6];
    ncmp = 0; nfail = 0;
    m_status = '0; m_mie = '0; m_mtvec = '0; m_mepc = '0; m_mcause = '0;
    addrs[0] = 12'h300; addrs[1] = 12'h304; addrs[2] = 12'h305;
    addrs[3] = 12'h341; addrs[4] = 12'h342; addrs[5] = 12'h7C0;
    idle_in();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset holds every output low, even with a request at the port.
    bus.inst_csr_wr = 1'b1; bus.inst_csr_addr = 12'h305; bus.inst_csr_wdata = 32'hDEAD_BEEF;
    tick();
    chk("rst_we", {31'd0, o_we}, 32'd0);
    chk("rst_wdata", o_data, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    idle_in();
    tick();
    rst = 1'b0;

    // Direct-mode timer trap.
    m_status = 32'h8; m_mie = 32'h80; m_mtvec = 32'h100;
    bus.irq_timer = 1; bus.inst_valid = 1; bus.pc_in = 32'h40;
    bus.inst_csr_wr = 1; bus.inst_csr_addr = 12'h305; bus.inst_csr_wdata = 32'h5;
    tick();
    chk("t_mepc_addr", {20'd0, o_addr}, 32'h341);
    chk("t_mepc_data", o_data, 32'h40);
    chk("t_kill", {31'd0, o_kill}, 32'd1);
    bus.inst_valid = 0; bus.inst_csr_wr = 0;
    tick();
    chk("t_mcause", o_data, 32'h8000_0007);
    chk("t_stall1", {31'd0, o_stall}, 32'd1);
    tick();
    chk("t_mstatus", o_data, 32'h1880);
    tick();
    chk("t_target", o_target, 32'h100);
    chk("t_redir", {31'd0, o_redir}, 32'd1);
    bus.irq_timer = 0;
    tick();
    chk("t_idle", {31'd0, o_busy}, 32'd0);

    // mret back to mepc.
    m_mepc = 32'h44;
    bus.inst_valid = 1; bus.is_mret = 1; bus.pc_in = 32'h104;
    tick();
    chk("m_status", o_data, 32'h1888);
    chk("m_addr", {20'd0, o_addr}, 32'h300);
    bus.inst_valid = 0; bus.is_mret = 0;
    tick();
    chk("m_target", o_target, 32'h44);
    tick();
    chk("m_idle", {31'd0, o_busy}, 32'd0);

    // Vectored: external beats timer.
    m_mtvec = 32'h201; m_mie = 32'h880;
    bus.irq_timer = 1; bus.irq_ext = 1; bus.inst_valid = 1; bus.pc_in = 32'h77;
    tick();
    chk("v_mepc", o_data, 32'h74);
    bus.inst_valid = 0;
    tick();
    chk("v_mcause", o_data, 32'h8000_000B);
    tick();
    tick();
    chk("v_target", o_target, 32'h22C);
    bus.irq_timer = 0; bus.irq_ext = 0;
    tick();

    // Masked interrupt, instruction write passes through.
    m_status = 32'h0; m_mie = 32'h80;
    bus.irq_timer = 1; bus.inst_valid = 1;
    bus.inst_csr_wr = 1; bus.inst_csr_addr = 12'h305; bus.inst_csr_wdata = 32'h300;
    tick();
    chk("p_addr", {20'd0, o_addr}, 32'h305);
    chk("p_data", o_data, 32'h300);
    chk("p_kill", {31'd0, o_kill}, 32'd0);
    idle_in();
    tick();
    chk("p_busy", {31'd0, o_busy}, 32'd0);

    // Trap and mret collide: trap wins.
    m_status = 32'h8;
    bus.irq_timer = 1; bus.inst_valid = 1; bus.is_mret = 1; bus.pc_in = 32'h48;
    tick();
    chk("c_kill", {31'd0, o_kill}, 32'd1);
    chk("c_addr", {20'd0, o_addr}, 32'h341);
    chk("c_mepc", o_data, 32'h48);
    bus.inst_valid = 0; bus.is_mret = 0;
    tick();
    chk("c_next", {20'd0, o_addr}, 32'h342);
    tick();
    tick();
    bus.irq_timer = 0;
    tick();

    // Reset while in STATUS.
    m_status = 32'h8;
    bus.irq_timer = 1; bus.inst_valid = 1; bus.pc_in = 32'h60;
    tick();
    bus.inst_valid = 0;
    tick();
    rst = 1;
    tick();
    chk("r_we", {31'd0, o_we}, 32'd0);
    chk("r_stall", {31'd0, o_stall}, 32'd0);
    chk("r_data", o_data, 32'd0);
    rst = 0; bus.irq_timer = 0;
    tick();
    chk("r_idle", {31'd0, o_busy}, 32'd0);
    chk("r_nowr", {31'd0, o_we}, 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst                = ($urandom_range(0, 199) == 0);
      bus.irq_timer      = ($urandom_range(0, 2) == 0);
      bus.irq_ext        = ($urandom_range(0, 3) == 0);
      bus.inst_valid     = ($urandom_range(0, 3) != 0);
      bus.is_mret        = ($urandom_range(0, 7) == 0);
      bus.pc_in          = $urandom;
      bus.inst_csr_wr    = ($urandom_range(0, 3) == 0);
      bus.inst_csr_addr  = addrs[$urandom_range(0, 5)];
      bus.inst_csr_wdata = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
